imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 159 +++++++++++++++
 tb/tb_imem_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length-prefixed byte stream -> 32-bit imem writes.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK    = 3'd5,
`endif
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t END_ST = CHK;
`else
    localparam state_t END_ST = DONE;
`endif

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    state_t                state, state_n;
    logic [ADDR_WIDTH:0]   idx;
    logic [1:0]            lane;
    logic [15:0]           len_q;
    logic [31:0]           wd_q;
    logic                  xfer;
    logic [16:0]           idx_inc;
    logic [15:0]           len_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    assign xfer    = byte_valid && byte_ready;
    // index is one bit wider than the address so N = capacity compares without wrapping
    assign idx_inc = 17'(idx) + 17'd1;
    assign len_n   = {byte_data, len_q[7:0]};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_n = LEN_LO;
            LEN_LO:          if (xfer) state_n = LEN_HI;
            LEN_HI: begin
                if (xfer) begin
                    if (len_n == 16'd0)               state_n = END_ST;
                    else if ({1'b0, len_n} > CAPACITY) state_n = ERR;
                    else                               state_n = DATA;
                end
            end
            DATA:            if (xfer && lane == 2'd3) state_n = WRITE;
            WRITE:           state_n = (idx_inc == {1'b0, len_q}) ? END_ST : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:             if (xfer) state_n = (byte_data == csum) ? DONE : ERR;
`endif
            default:         state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx   <= '0;
            lane  <= '0;
            len_q <= '0;
            wd_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        idx  <= '0;
                        lane <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= '0;
`endif
                    end
                end
                LEN_LO: if (xfer) len_q[7:0]  <= byte_data;
                LEN_HI: if (xfer) len_q[15:8] <= byte_data;
                DATA: begin
                    if (xfer) begin
                        wd_q[{lane, 3'b000} +: 8] <= byte_data;
                        lane                      <= lane + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum                      <= csum ^ byte_data;
`endif
                    end
                end
                WRITE:   idx <= idx_inc[ADDR_WIDTH:0];
                default: ;
            endcase
        end
    end

    // every output is a register or a decode of the registered state
    always_comb begin
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        core_reset = 1'b1;
        case (state)
            LEN_LO, LEN_HI, DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`endif
            DONE: begin
                done       = 1'b1;
                core_reset = 1'b0;
            end
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr  = 32'({idx, 2'b00});
    assign imem_wd    = wd_q;
    assign word_count = len_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader (ADDR_WIDTH=2) against a stream-parsing model.
module tb_imem_loader;
    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic        clk = 1'b0;
    logic        reset, start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, imem_we, core_reset, busy, done, err;
    logic [31:0] imem_addr, imem_wd;
    logic [15:0] word_count;

    int errors = 0;
    int checks = 0;
    logic [63:0] got[$];

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wd(imem_wd), .core_reset(core_reset),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // write monitor: capture every strobe and confirm no byte can be taken in a WRITE cycle
    always @(negedge clk) begin
        if (imem_we) begin
            got.push_back({imem_addr, imem_wd});
            chk("we_ready_low", 64'(byte_ready), 64'd0);
        end
    end

    // reference: parse the byte stream the way the format describes it
    function automatic void model(input logic [7:0] s[$], output logic [63:0] w[$], output bit ok);
        int n;
        logic [7:0]  x;
        logic [31:0] word;
        w  = {};
        ok = 1'b1;
        x  = 8'h00;
        n  = int'({s[1], s[0]});
        if (n > CAP) begin
            ok = 1'b0;
            return;
        end
        for (int k = 0; k < n; k++) begin
            word = {s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]};
            x    = x ^ s[2+4*k] ^ s[2+4*k+1] ^ s[2+4*k+2] ^ s[2+4*k+3];
            w.push_back({32'(k * 4), word});
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (s[2+4*n] != x) ok = 1'b0;
`endif
    endfunction

    function automatic void add_chk(inout logic [7:0] s[$], input bit bad);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        for (int i = 2; i < s.size(); i++) x ^= s[i];
        s.push_back(bad ? (x ^ 8'h5A) : x);
`else
        if (bad) s = s;
`endif
    endfunction

    function automatic void build(input int n, input bit bad, output logic [7:0] s[$]);
        logic [15:0] nn = 16'(n);
        s = {};
        s.push_back(nn[7:0]);
        s.push_back(nn[15:8]);
        if (n <= CAP) begin
            for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
            add_chk(s, bad);
        end
    endfunction

    task automatic send(input logic [7:0] s[$], input int pv);
        int i = 0;
        int guard = 0;
        logic rdy;
        while (i < s.size() && guard < 3000) begin
            @(negedge clk);
            rdy        = byte_ready;
            byte_valid = ($urandom_range(99) < pv);
            byte_data  = byte_valid ? s[i] : 8'($urandom);
            @(posedge clk);
            if (byte_valid && rdy) i++;
            guard++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        if (guard >= 3000) chk("send_timeout", 64'(i), 64'(s.size()));
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_rdy"}, 64'(byte_ready), 64'd1);
        chk({tag, "_crst"}, 64'(core_reset), 64'd1);
        chk({tag, "_clr"}, 64'({done, err}), 64'd0);
    endtask

    task automatic run_load(input logic [7:0] s[$], input int pv, input string tag);
        logic [63:0] exp_w[$];
        bit ok;
        int t = 0;
        model(s, exp_w, ok);
        got = {};
        pulse_start(tag);
        send(s, pv);
        while (!(done || err) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk({tag, "_end_timeout"}, 64'd0, 64'd1);
        chk({tag, "_done"}, 64'(done), 64'(ok));
        chk({tag, "_err"}, 64'(err), 64'(!ok));
        chk({tag, "_crst"}, 64'(core_reset), 64'(!ok));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_wc"}, 64'(word_count), 64'({s[1], s[0]}));
        chk({tag, "_nw"}, 64'(got.size()), 64'(exp_w.size()));
        for (int k = 0; k < exp_w.size(); k++)
            chk({tag, "_w"}, got[k], exp_w[k]);
    endtask

    initial begin
        logic [7:0] s[$];
        logic [7:0] p[$];
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_crst", 64'(core_reset), 64'd1);
        chk("rst_flags", 64'({busy, done, err}), 64'd0);
        chk("rst_hs", 64'({byte_ready, imem_we}), 64'd0);
        chk("rst_data", {imem_addr, imem_wd}, 64'd0);
        chk("rst_wc", 64'(word_count), 64'd0);
        reset = 1'b0;

        s = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        add_chk(s, 1'b0);
        run_load(s, 100, "two_word");
        chk("two_word_w0", got[0], {32'h0, 32'h00A00513});
        chk("two_word_w1", got[1], {32'h4, 32'h0000006F});
        run_load(s, 40, "two_word_bp");

        build(CAP, 1'b0, s);     run_load(s, 70, "n_cap");
        build(CAP + 1, 1'b0, s); run_load(s, 70, "n_over");
        build(0, 1'b0, s);       run_load(s, 70, "n_zero");
        start = 1'b0;

        for (int r = 0; r < 8; r++) begin
            build($urandom_range(CAP), 1'b0, s);
            run_load(s, $urandom_range(100, 20), "rand");
        end

        // mid-load reset after header plus six data bytes
        build(2, 1'b0, s);
        p = s[0:7];
        pulse_start("mid");
        send(p, 60);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_crst", 64'(core_reset), 64'd1);
        chk("mid_rst_flags", 64'({busy, done, err, byte_ready, imem_we}), 64'd0);
        chk("mid_rst_data", {imem_addr, imem_wd}, 64'd0);
        chk("mid_rst_wc", 64'(word_count), 64'd0);
        reset = 1'b0;
        run_load(s, 80, "reload");

`ifdef IMEM_LOADER_CHECKSUM_EN
        build(3, 1'b1, s); run_load(s, 80, "chk_bad");
        build(3, 1'b0, s); run_load(s, 80, "chk_good");
        build(0, 1'b1, s); run_load(s, 80, "chk_bad0");
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
